tt_um_adder_sequencer: RTL and testbench

TT_UM_ADDER_SEQUENCER -- requirements
Module: tt_um_adder_sequencer

---
 rtl/tt_um_adder_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_tt_um_adder_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_adder_sequencer.sv
// Sequenced 8-bit adder: captures two operands on start pulses and adds
// them in a single EXEC cycle, with an accumulate mode that reuses the
// previous result as operand A.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   ena     - design enable; low freezes every register
//   ui_in   - operand data bus
//   uio_in  - [0] start, [1] accum mode, [2] ack, [3] clear
//   uo_out  - registered result
//   uio_out - [4] busy, [5] done, [6] carry, [7] sticky overflow
//   uio_oe  - constant 8'hF0
//
// Build option: define ADDER_SEQ_SAT_EN to saturate result/acc to 8'hFF
// on carry-out instead of wrapping modulo 256.

module tt_um_adder_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic       start_q, start_d;
  logic       armed_q, armed_d;
  logic       mode_q, mode_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;

  logic       start_raw;
  logic       accum_in;
  logic       ack_in;
  logic       clr_in;
  logic       start_evt;
  logic [8:0] sum;
  logic [7:0] res_v;
  logic       busy;
  logic       done;
  logic       unused_uio;

  assign start_raw  = uio_in[0];
  assign accum_in   = uio_in[1];
  assign ack_in     = uio_in[2];
  assign clr_in     = uio_in[3];
  assign unused_uio = ^uio_in[7:4];

  // armed_q is low only on the first enabled edge after reset, so a start
  // line already high when reset releases is not seen as a rising edge.
  assign start_evt = start_raw & ~start_q & armed_q;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADDER_SEQ_SAT_EN
  assign res_v = sum[8] ? 8'hFF : sum[7:0];
`else
  assign res_v = sum[7:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides start and ack
  always_comb begin
    state_d = state_q;
    if (clr_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt) begin
            state_d = accum_in ? EXEC : WAIT_B;
          end
        end
        WAIT_B: begin
          if (start_evt) begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (ack_in) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    start_d  = start_raw;
    armed_d  = 1'b1;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (clr_in) begin
      mode_d   = 1'b0;
      a_d      = 8'h00;
      b_d      = 8'h00;
      acc_d    = 8'h00;
      result_d = 8'h00;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt) begin
            // mode is latched here only; later changes are ignored
            mode_d = accum_in;
            if (accum_in) begin
              a_d = acc_q;
              b_d = ui_in;
            end else begin
              a_d = ui_in;
            end
          end
        end
        WAIT_B: begin
          if (start_evt) begin
            b_d = ui_in;
          end
        end
        EXEC: begin
          result_d = res_v;
          acc_d    = res_v;
          carry_d  = sum[8];
          if (mode_q && sum[8]) begin
            ovf_d = 1'b1;
          end
        end
        HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      mode_q   <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      acc_q    <= 8'h00;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ena) begin
      start_q  <= start_d;
      armed_q  <= armed_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      WAIT_B:  busy = 1'b1;
      EXEC:    busy = 1'b1;
      HOLD:    done = 1'b1;
      default: begin
      end
    endcase
  end

  assign uo_out  = result_q;
  assign uio_out = {ovf_q, carry_q, done, busy, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_adder_sequencer.sv
// Directed self-checking bench for tt_um_adder_sequencer.
// Drives start/ack/clear sequences and checks result and status bits.

module tb_tt_um_adder_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic st, acm, ak, clr;

  int tests;
  int fails;

  assign uio_in = {4'h0, clr, ak, acm, st};

  tt_um_adder_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    ui_in = v;
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
  endtask

  task automatic do_ack();
    ak = 1'b1;
    tick();
    ak = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    st    = 1'b0;
    acm   = 1'b0;
    ak    = 1'b0;
    clr   = 1'b0;

    #12;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();

    // 12 + 34, plain mode
    ui_in = 8'h12;
    st = 1'b1;
    tick();
    chk("b_wait_busy", uio_out, 8'h10);
    st = 1'b0;
    tick();
    ui_in = 8'h34;
    st = 1'b1;
    tick();
    chk("exec_busy", uio_out, 8'h10);
    st = 1'b0;
    tick();
    chk("add_uo", uo_out, 8'h46);
    chk("add_done", uio_out, 8'h20);
    do_ack();
    chk("ack_idle", uio_out, 8'h00);
    chk("ack_uo_hold", uo_out, 8'h46);

    // F0 + 20, carry out
    pulse(8'hF0);
    pulse(8'h20);
`ifdef ADDER_SEQ_SAT_EN
    chk("carry_uo", uo_out, 8'hFF);
`else
    chk("carry_uo", uo_out, 8'h10);
`endif
    chk("carry_st", uio_out, 8'h60);
    do_ack();
    chk("carry_idle", uio_out, 8'h40);

    // clear, then accumulate 80 and 90
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_uo", uo_out, 8'h00);
    chk("clr_uio", uio_out, 8'h00);
    acm = 1'b1;
    ui_in = 8'h80;
    st = 1'b1;
    tick();
    chk("acc_exec", uio_out, 8'h10);
    st = 1'b0;
    tick();
    tick();
    chk("lat_uo", uo_out, 8'h80);
    chk("lat_done", uio_out, 8'h20);
    // start ignored in HOLD
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    chk("hold_ign", uio_out, 8'h20);
    do_ack();
    pulse(8'h90);
`ifdef ADDER_SEQ_SAT_EN
    chk("ovf_uo", uo_out, 8'hFF);
`else
    chk("ovf_uo", uo_out, 8'h10);
`endif
    chk("ovf_st", uio_out, 8'hE0);
    do_ack();
    chk("ovf_idle", uio_out, 8'hC0);
    pulse(8'h00);
    chk("ovf_sticky", uio_out, 8'hA0);
    do_ack();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_uo", uo_out, 8'h00);
    chk("clr2_uio", uio_out, 8'h00);

    // start held high: one capture only; accum change mid-op ignored
    acm = 1'b0;
    ui_in = 8'h05;
    st = 1'b1;
    tick();
    ui_in = 8'h09;
    tick();
    tick();
    chk("held_wait", uio_out, 8'h10);
    st = 1'b0;
    acm = 1'b1;
    tick();
    ui_in = 8'h07;
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    chk("held_uo", uo_out, 8'h0C);
    chk("held_st", uio_out, 8'h20);
    do_ack();
    acm = 1'b0;

    // clear beats start
    clr = 1'b1;
    st = 1'b1;
    ui_in = 8'h33;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_start", uio_out, 8'h00);
    chk("clr_start_uo", uo_out, 8'h00);
    st = 1'b0;
    tick();

    // async reset while in WAIT_B
    pulse(8'h01);
    pulse(8'h02);
    chk("pre_rst_uo", uo_out, 8'h03);
    do_ack();
    pulse(8'h44);
    chk("rst_wait", uio_out, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h00);
    st = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rel_start", uio_out, 8'h00);
    tick();
    chk("rel_start2", uio_out, 8'h00);
    st = 1'b0;
    tick();

    // ena low during a start pulse
    ena = 1'b0;
    ui_in = 8'h55;
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    ena = 1'b1;
    tick();
    chk("ena_uio", uio_out, 8'h00);
    chk("ena_uo", uo_out, 8'h00);

    // normal operation afterwards
    pulse(8'h0A);
    pulse(8'h0B);
    chk("final_uo", uo_out, 8'h15);
    chk("final_st", uio_out, 8'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
